data_memory_pipe: RTL
=====================

# data_memory_pipe

Parametrised single-port data memory with a valid/ready request interface, byte-lane write strobes, a configurable read pipeline of 1 or 2 cycles, and an optional hardware clear sequence after reset. It sits between the datapath load/store unit and on-chip storage. It is the next-generation store for `lw`/`sw` traffic. Requests are accepted only when the block is ready, and read data returns with a fixed, parameter-defined latency.

## Interface
Parameters:
- DATA_WIDTH, default 8: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, default 8: address width; DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, default 1: cycles from read acceptance to rsp_valid; legal values are 1 and 2.
- CLEAR_ON_RESET, default 1: when 1, every word is zeroed after reset before the first request is accepted.

Ports:
- sysclk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  store data.
- req_wstrb  in  DATA_WIDTH/8  byte-lane enables for stores; bit i covers bits 8i+7:8i.
- rsp_valid  out  1  one-cycle pulse; rsp_rdata is valid this cycle.
- rsp_rdata  out  DATA_WIDTH  load data.
- busy  out  1  clear sequence in progress.

## Operation
- The FSM has two states, CLEAR and READY.
- **Reset.** While reset is high: state = CLEAR if CLEAR_ON_RESET else READY. Also clear_cnt = 0, the read pipeline is flushed, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, and busy = CLEAR_ON_RESET.
- **CLEAR.**
  - Each edge with reset low writes 0 to mem[clear_cnt] and increments clear_cnt.
  - After the write at clear_cnt = DEPTH-1, the next state is READY and busy falls.
  - req_ready = 0 throughout; requests presented in CLEAR are ignored and not queued.
- **READY.**
  - req_ready = 1 whenever reset is low.
  - A request is accepted on an edge where req_valid && req_ready.
- **Store accept.**
  - For each lane i with req_wstrb[i] = 1, mem[req_addr] lane i takes req_wdata lane i at that edge.
  - Lanes with strobe 0 are unchanged. A store with req_wstrb = 0 is accepted and changes nothing.
  - Stores produce no response.
- **Load accept.** mem[req_addr] is sampled at the acceptance edge; it is returned READ_LATENCY cycles later.
- **Throughput.** One request per cycle, with no bubbles between any mix of loads and stores.
- **Ordering.**
  - A load accepted the cycle after a store to the same address returns the new data.
  - Loads return in acceptance order.
- **Response side.** There is no backpressure on the response; the consumer must accept every rsp_valid pulse.
- **rsp_rdata** holds its last value while rsp_valid = 0.
- **Address range.** Addresses cover the full range; there is no out-of-range case. No wrap logic is needed beyond ADDR_WIDTH truncation.
- **Reset mid-operation.**
  - Loads in flight are discarded and never produce rsp_valid.
  - Stores already accepted remain in memory unless overwritten by the clear sequence.
  - With CLEAR_ON_RESET = 1, the clear sequence restarts from address 0.
- **Initial contents.** With CLEAR_ON_RESET = 0, memory contents at power-up are undefined; the bench preloads them.

## Timing
- **Clear duration.** Reset is deasserted before edge E0. With CLEAR_ON_RESET = 1:
  - Edges E0..E(DEPTH-1) perform the clears.
  - busy = 1 and req_ready = 0 through cycle E(DEPTH-1).
  - req_ready = 1 from the cycle after E(DEPTH-1), i.e. after DEPTH edges; this is 256 edges for the defaults.
- **No clear.** With CLEAR_ON_RESET = 0, req_ready = 1 in the first cycle reset is low.
- **Load latency.** A load is accepted at edge A.
  - READ_LATENCY = 1: rsp_valid = 1 in the cycle after A, with data registered at A.
  - READ_LATENCY = 2: one extra output register stage; rsp_valid = 1 for the cycle following edge A+1.
- **Response pulse.** rsp_valid is high for exactly one cycle per accepted load.
- **Store visibility.** The write takes effect at the acceptance edge. A load accepted at the next edge sees the new data.
- **Reset priority.** Reset asserted at edge R has priority over any request presented at R. That request is not accepted and memory is not written, apart from already-accepted state.

## Test plan
- Clear after reset (defaults): deassert reset. Check busy = 1 and req_ready = 0 for 256 edges, then req_ready = 1. Load addresses 0x00, 0x7F and 0xFF; each returns 0x00.
- Store/load turnaround (READ_LATENCY = 1): store 0xA5 to 0x10, then load 0x10 on the next cycle. Expect rsp_valid one cycle after the load is accepted, with rsp_rdata = 0xA5.
- Byte strobes (DATA_WIDTH = 32): store 0x11223344 with wstrb 0xF, then store 0xAABBCCDD with wstrb 0x5 to the same address. A load returns 0x11BB33DD.
- Back-to-back loads (READ_LATENCY = 2): addresses 1, 2 and 3 hold 0x01, 0x02 and 0x03. Issue three consecutive loads. Expect three consecutive rsp_valid pulses, starting 2 cycles after the first accept, with data 0x01, 0x02, 0x03 in order.
- Blocked request during clear: hold req_valid = 1 as a store of 0xFF to 0x05 during CLEAR. The store is not accepted and a later load of 0x05 returns 0x00.
- Reset mid-read: accept a load, then assert reset on the next edge. rsp_valid never pulses for that load; busy = 1 and the clear restarts at address 0.

Source files
------------

// File: rtl/data_memory_pipe.sv
// Single-port data memory with valid/ready requests, byte-lane strobes and a
// 1- or 2-cycle read pipeline. An optional post-reset sweep zeroes every word.
module data_memory_pipe #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int LANES  = DATA_WIDTH / 8;
    localparam int STAGES = (READ_LATENCY == 2) ? 2 : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = ADDR_WIDTH'(1);

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clear_cnt_q;
    logic                    ready_q;
    logic                    busy_q;
    logic [STAGES-1:0]       vld_q;
    logic [DATA_WIDTH-1:0]   data_q [STAGES];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    accept, wr_en, rd_en, clr_en;

    // Reset acts on the same cycle it is seen, so it gates the outputs directly.
    assign req_ready = ready_q & ~reset;
    assign busy      = reset ? (CLEAR_ON_RESET != 0) : busy_q;
    assign rsp_valid = vld_q[STAGES-1] & ~reset;
    assign rsp_rdata = reset ? '0 : data_q[STAGES-1];

    assign accept = req_valid & req_ready;
    assign wr_en  = accept & req_write;
    assign rd_en  = accept & ~req_write;
    assign clr_en = (state_q == ST_CLEAR) & ~reset;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clear_cnt_q <= '0;
            ready_q     <= (CLEAR_ON_RESET == 0);
            busy_q      <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clear_cnt_q <= clear_cnt_q + CNT_ONE;
                    if (clear_cnt_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // One byte-wide array per lane so each strobe maps to an independent write enable.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem_q [DEPTH];

        always_ff @(posedge sysclk) begin
            if (clr_en)
                mem_q[clear_cnt_q] <= '0;
            else if (wr_en && req_wstrb[l])
                mem_q[req_addr] <= req_wdata[8*l +: 8];
        end

        assign rd_word[8*l +: 8] = mem_q[req_addr];
    end

    // Each stage only loads on a valid input, so the output holds between pulses.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            vld_q <= '0;
            for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) data_q[0] <= rd_word;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) data_q[s] <= data_q[s-1];
            end
        end
    end

endmodule
